// File: rtl/cpu_mulx_pkg.sv
// Shared types and helpers for the multi-cycle 32x32->64 multiply sequencer.
// Holds the FSM state encoding, width constants and the signed-correction term.
package cpu_mulx_pkg;

  localparam int DATA_W = 32;
  localparam int H      = DATA_W / 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_P4   = 3'd5,
    ST_CORR = 3'd6,
    ST_DONE = 3'd7
  } mulx_state_t;

  // Amount to subtract from the unsigned product to get the two's-complement one.
  function automatic logic [63:0] corr_term(input logic [31:0] a, input logic [31:0] b,
                                            input logic s1, input logic s2);
    logic [63:0] t;
    t = '0;
    if (s1 && a[31]) t = t + {b, 32'h0};
    if (s2 && b[31]) t = t + {a, 32'h0};
    return t;
  endfunction

endpackage

// File: rtl/cpu_mulx_pp16.sv
// Registered 16x16 unsigned partial-product multiplier; latency STAGES cycles.
// No backpressure: a new operand pair is accepted every cycle.
module cpu_mulx_pp16 #(
  parameter int STAGES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);

  logic [31:0] pipe [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= x * y;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[STAGES-1];

endmodule

// File: rtl/cpu_mulx_seq.sv
// Full 64-bit product of two 32-bit operands over one shared 16x16 multiplier.
// Latency: done 8 cycles after an accepted start; start is dropped while busy.
module cpu_mulx_seq #(
  parameter int DATA_W   = 32,
  parameter int MUL_PIPE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              A_mulx_start,
  input  logic [DATA_W-1:0] A_mulx_src1,
  input  logic [DATA_W-1:0] A_mulx_src2,
  input  logic              A_mulx_signed1,
  input  logic              A_mulx_signed2,
  output logic              A_mulx_busy,
  output logic              A_mulx_done,
  output logic [DATA_W-1:0] A_mulx_result_hi,
  output logic [DATA_W-1:0] A_mulx_result_lo
);
  import cpu_mulx_pkg::*;

  mulx_state_t       state, state_nxt;
  logic [DATA_W-1:0] op_a, op_b;
  logic              sgn_a, sgn_b;
  logic [2*DATA_W-1:0] acc;
  logic [H-1:0]      pp_x, pp_y;
  logic [2*H-1:0]    pp_p;

  cpu_mulx_pp16 #(.STAGES(MUL_PIPE)) u_pp16 (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (pp_x),
    .y       (pp_y),
    .p       (pp_p)
  );

  // Multiplier operands are selected in state Pn; the product lands one state later.
  always_comb begin
    state_nxt = state;
    pp_x      = '0;
    pp_y      = '0;
    case (state)
      ST_IDLE: if (A_mulx_start) state_nxt = ST_P0;
      ST_P0: begin
        pp_x = op_a[H-1:0];   pp_y = op_b[H-1:0];   state_nxt = ST_P1;
      end
      ST_P1: begin
        pp_x = op_a[2*H-1:H]; pp_y = op_b[H-1:0];   state_nxt = ST_P2;
      end
      ST_P2: begin
        pp_x = op_a[H-1:0];   pp_y = op_b[2*H-1:H]; state_nxt = ST_P3;
      end
      ST_P3: begin
        pp_x = op_a[2*H-1:H]; pp_y = op_b[2*H-1:H]; state_nxt = ST_P4;
      end
      ST_P4:   state_nxt = ST_CORR;
      ST_CORR: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign A_mulx_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a             <= '0;
      op_b             <= '0;
      sgn_a            <= 1'b0;
      sgn_b            <= 1'b0;
      acc              <= '0;
      A_mulx_done      <= 1'b0;
      A_mulx_result_hi <= '0;
      A_mulx_result_lo <= '0;
    end else begin
      A_mulx_done <= 1'b0;
      case (state)
        ST_IDLE: if (A_mulx_start) begin
          op_a  <= A_mulx_src1;
          op_b  <= A_mulx_src2;
          sgn_a <= A_mulx_signed1;
          sgn_b <= A_mulx_signed2;
          acc   <= '0;
        end
        ST_P1:   acc <= {{DATA_W{1'b0}}, pp_p};
        ST_P2,
        ST_P3:   acc <= acc + {{H{1'b0}}, pp_p, {H{1'b0}}};
        ST_P4:   acc <= acc + {pp_p, {DATA_W{1'b0}}};
        ST_CORR: acc <= acc - corr_term(op_a, op_b, sgn_a, sgn_b);
        ST_DONE: begin
          A_mulx_result_hi <= acc[2*DATA_W-1:DATA_W];
          A_mulx_result_lo <= acc[DATA_W-1:0];
          A_mulx_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mulx_seq.sv
// Directed and randomised checks of the multi-cycle multiply sequencer.
module tb_cpu_mulx_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        sg1 = 1'b0, sg2 = 1'b0;
  logic        busy, done;
  logic [31:0] res_hi, res_lo;

  int n_checks = 0;
  int n_err    = 0;

  cpu_mulx_seq #(.DATA_W(32), .MUL_PIPE(1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .A_mulx_start     (start),
    .A_mulx_src1      (src1),
    .A_mulx_src2      (src2),
    .A_mulx_signed1   (sg1),
    .A_mulx_signed2   (sg2),
    .A_mulx_busy      (busy),
    .A_mulx_done      (done),
    .A_mulx_result_hi (res_hi),
    .A_mulx_result_lo (res_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference via sign/zero extension to 64 bits and a modulo-2^64 multiply.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s1, input logic s2);
    logic [63:0] ea, eb;
    ea = s1 ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s2 ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // One operation: start at a negedge, then scramble inputs to prove they were latched.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s1, input logic s2,
                       output logic [63:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    src1 = a; src2 = b; sg1 = s1; sg2 = s2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src1 = $urandom; src2 = $urandom; sg1 = 1'($urandom); sg2 = 1'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    res = {res_hi, res_lo};
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        s1, s2;
    logic [63:0] exp;
    string       tag;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] res;
  int          lat, bcnt;
  logic [63:0] q_exp [$];
  int          n_acc, n_done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, "uu_max"};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, "ss_m1"};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, "ss_min"};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, "su_m1"};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, "uu_mid"};
    vecs[5] = '{32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "us_neg"};

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(res_hi), 64'd0);
    chk("rst_lo", 64'(res_lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors; first one also checks timing and pulse width
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s1, vecs[i].s2, res, lat, bcnt);
      chk(vecs[i].tag, res, vecs[i].exp);
      if (i == 0) begin
        chk("latency", 64'(lat), 64'd8);
        chk("busy_cycles", 64'(bcnt), 64'd7);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("result_hold", {res_hi, res_lo}, vecs[0].exp);
      end
    end

    // Start held high for 20 cycles: accepts at cycles 0, 8, 16 only
    n_acc = 0; n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (q_exp.size() > 0) chk("pulse_res", {res_hi, res_lo}, q_exp.pop_front());
        else chk("pulse_extra_done", 64'd1, 64'd0);
      end
      if (c < 20) begin
        src1 = $urandom; src2 = $urandom; sg1 = 1'($urandom); sg2 = 1'($urandom);
        start = 1'b1;
        if (!busy) begin
          n_acc++;
          q_exp.push_back(ref_mul(src1, src2, sg1, sg2));
        end
      end else begin
        start = 1'b0;
      end
    end
    chk("pulse_accepts", 64'(n_acc), 64'd3);
    chk("pulse_dones", 64'(n_done), 64'd3);

    // Asynchronous reset during P2
    @(negedge clk);
    src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; sg1 = 1'b0; sg2 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(res_hi), 64'd0);
    chk("arst_lo", 64'(res_lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("arst_no_done", 64'(n_done), 64'd0);
    do_op(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, res, lat, bcnt);
    chk("after_arst", res, 64'd15);
    chk("after_arst_lat", 64'(lat), 64'd8);

    // Randomised operands and sign flags against the extension model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      logic        r1, r2;
      ra = $urandom; rb = $urandom; r1 = 1'($urandom); r2 = 1'($urandom);
      if (i % 8 == 0) ra = {1'b1, 31'($urandom_range(0, 3))};
      if (i % 8 == 1) rb = 32'h8000_0000;
      do_op(ra, rb, r1, r2, res, lat, bcnt);
      chk("rand", res, ref_mul(ra, rb, r1, r2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
